vector_mem_sequencer: RTL and testbench
=======================================

# vector_mem_sequencer

Multi-cycle sequencer for vector (4-lane × 32-bit) load and store instructions. It accepts one decoded vector memory op, walks lanes 0..3 over the single 32-bit data port of `memory`, and writes loaded lanes into `RegisterSet2` one column per cycle. While busy it holds the program counter. It sits between `control_unit`, `memory` (shared data port, granted by fetch-side logic) and `RegisterSet2`, and replaces the free-running `counter_column` lane stepping.

## Interface
Parameters:
- `LANES`, 4, lanes per vector register; lane index width is 2.
- `ADDR_W`, 8, memory address width.
- `DATA_W`, 32, lane width; the vector is `LANES*DATA_W` = 128 bits.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset state immediately.
- `op_valid`  in  1  decoded vector memory op present.
- `op_ready`  out  1  op accepted this cycle (`op_valid & op_ready` = accept).
- `op_store`  in  1  1 = store (ST [base], rX), 0 = load (LD rX, [base]).
- `op_base`  in  8  base address (immediate[7:0]).
- `op_reg`  in  4  vector register index (load destination).
- `store_vec`  in  128  register read data; lane k = bits [32k+31:32k].
- `mem_req`  out  1  data-port request.
- `mem_we`  out  1  write strobe; valid only with `mem_req`.
- `mem_addr`  out  8  lane address.
- `mem_wdata`  out  32  store lane data.
- `mem_gnt`  in  1  data port granted this cycle.
- `mem_rdata`  in  32  read data, valid the cycle after a granted read.
- `rf_we`  out  1  register-file lane write.
- `rf_waddr_r`  out  4  register index.
- `rf_waddr_c`  out  2  lane (column) index.
- `rf_wdata`  out  32  lane write data.
- `pc_stall`  out  1  hold program counter.
- `lane`  out  2  current lane (debug / offset).
- `done`  out  1  one-cycle pulse: op complete.

## Operation
- States: IDLE, ISSUE, RDWAIT, DONE.
- IDLE: `op_ready`=1. On accept: register `op_store`, `op_base`, `op_reg`, `store_vec`; lane←0; → ISSUE.
- ISSUE: `mem_req`=1, `mem_we`=captured store flag, `mem_addr`=(base+lane) mod 256, `mem_wdata`=captured lane slice.
  - `mem_gnt`=0: stay; address/data/we held stable.
  - Grant, store: lane==3 → DONE, else lane+1, stay ISSUE.
  - Grant, load: → RDWAIT.
- RDWAIT: `mem_req`=0; `rf_we`=1, `rf_waddr_r`=captured reg, `rf_waddr_c`=lane, `rf_wdata`=`mem_rdata`. lane==3 → DONE, else lane+1 → ISSUE.
- DONE: `done`=1, lane←0; → IDLE unconditionally (no accept in DONE).
- `pc_stall` = (IDLE & `op_valid`) | ISSUE | RDWAIT; low in DONE so the PC advances in the same cycle as `done`.
- Address wraps: base 0xFE gives lanes 0xFE, 0xFF, 0x00, 0x01.
- Captured `store_vec` is used for the whole op; later changes on `store_vec` are ignored.
- `rf_we` is never asserted for stores; `mem_we` is never asserted for loads.
- All outputs not driven by the current state are 0.

## Timing
- Reset (`reset`=0): state IDLE, lane 0, captured registers 0; `op_ready`=1, all other outputs 0. Takes effect asynchronously.
- Reset mid-op aborts it. Pending lanes are not written, and there is no `done`.
- Store with `mem_gnt` held high: accept at t0, ISSUE lanes 0..3 at t1..t4, `done` at t5. That is 4 memory writes.
- Load with `mem_gnt` held high: ISSUE/RDWAIT alternate over t1..t8; RF writes at t2, t4, t6, t8; `done` at t9.
- Each cycle of `mem_gnt`=0 in ISSUE adds exactly one cycle.
- Back-to-back ops: the next accept is no earlier than the cycle after DONE.

## Test plan
- Store: base 0x10, `store_vec`=0x44444444_33333333_22222222_11111111, gnt=1 → writes 0x11111111@0x10, 0x22222222@0x11, 0x33333333@0x12, 0x44444444@0x13 at t1..t4; `done` at t5; `pc_stall` high t0..t4.
- Load: base 0x20, reg 5, memory 0xA0..0xA3 at 0x20..0x23 → RF writes (r5,c0)=0xA0 … (r5,c3)=0xA3 at t2, t4, t6, t8; `done` at t9.
- Grant stall: store, gnt=0 for 3 cycles on lane 1 → `mem_addr`/`mem_wdata` stable for those cycles; `done` at t8.
- Wrap: load base 0xFE → addresses 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-op: assert `reset`=0 during lane-2 RDWAIT of a load → `rf_we` drops immediately; no lane-3 write; no `done`; `op_ready`=1 after release.
- Back-to-back: store then load held on `op_valid` → second accept in the cycle after `done`, with `store_vec` changed mid-store having no effect on the written data.

Source files
------------

// File: rtl/vector_mem_sequencer_if.sv
// vector_mem_sequencer_if: op, data-port and register-file write bundle of the vector memory sequencer.
interface vector_mem_sequencer_if #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    localparam int LW = $clog2(LANES);
    logic                    op_valid;
    logic                    op_ready;
    logic                    op_store;
    logic [ADDR_W-1:0]       op_base;
    logic [3:0]              op_reg;
    logic [LANES*DATA_W-1:0] store_vec;
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_gnt;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    rf_we;
    logic [3:0]              rf_waddr_r;
    logic [LW-1:0]           rf_waddr_c;
    logic [DATA_W-1:0]       rf_wdata;
    logic                    pc_stall;
    logic [LW-1:0]           lane;
    logic                    done;
    modport master (
        input  op_valid, op_store, op_base, op_reg, store_vec, mem_gnt, mem_rdata,
        output op_ready, mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_waddr_r, rf_waddr_c, rf_wdata, pc_stall, lane, done
    );
    modport slave (
        output op_valid, op_store, op_base, op_reg, store_vec, mem_gnt, mem_rdata,
        input  op_ready, mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_waddr_r, rf_waddr_c, rf_wdata, pc_stall, lane, done
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: walks the lanes of one vector load/store over a 32-bit data port.
module vector_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic                    clk,
    input logic                    reset,
    vector_mem_sequencer_if.master bus
);
    localparam int LW = $clog2(LANES);
    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;
    state_t                  state;
    logic [LW-1:0]           idx;
    logic                    st;
    logic [ADDR_W-1:0]       base;
    logic [3:0]              rg;
    logic [LANES*DATA_W-1:0] vec;
    wire last  = idx == LW'(LANES - 1);
    wire issue = state == ISSUE;
    wire rdw   = state == RDWAIT;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            st    <= 1'b0;
            base  <= '0;
            rg    <= '0;
            vec   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.op_valid) begin
                    st    <= bus.op_store;
                    base  <= bus.op_base;
                    rg    <= bus.op_reg;
                    vec   <= bus.store_vec;
                    idx   <= '0;
                    state <= ISSUE;
                end
                ISSUE: if (bus.mem_gnt) begin
                    if (!st) state <= RDWAIT;
                    else if (last) state <= DONE;
                    else idx <= idx + 1'b1;
                end
                RDWAIT: begin
                    state <= last ? DONE : ISSUE;
                    if (!last) idx <= idx + 1'b1;
                end
                DONE: begin
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Outputs decode straight from the registered state so an async reset clears them at once.
    assign bus.op_ready   = state == IDLE;
    assign bus.mem_req    = issue;
    assign bus.mem_we     = issue & st;
    assign bus.mem_addr   = issue ? base + ADDR_W'(idx) : '0;
    assign bus.mem_wdata  = issue ? vec[DATA_W*idx +: DATA_W] : '0;
    assign bus.rf_we      = rdw;
    assign bus.rf_waddr_r = rdw ? rg : '0;
    assign bus.rf_waddr_c = rdw ? idx : '0;
    assign bus.rf_wdata   = rdw ? bus.mem_rdata : '0;
    assign bus.pc_stall   = (state == IDLE && bus.op_valid) || issue || rdw;
    assign bus.lane       = idx;
    assign bus.done       = state == DONE;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: directed checks of store, load, grant stall, wrap, abort and back-to-back ops.
module tb_vector_mem_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [256];
    vector_mem_sequencer_if bus ();
    vector_mem_sequencer dut (.clk(clk), .reset(reset), .bus(bus.master));
    always #5 clk = ~clk;
    always @(posedge clk)
        if (bus.mem_req && bus.mem_gnt) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [31:0] sw [4];
        logic seen;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.op_valid = 0; bus.op_store = 0; bus.op_base = 0; bus.op_reg = 0;
        bus.store_vec = 0; bus.mem_gnt = 0; bus.mem_rdata = 0;
        #2;
        chk("rst op_ready", 32'(bus.op_ready), 1);
        chk("rst mem_req", 32'(bus.mem_req), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst pc_stall", 32'(bus.pc_stall), 0);
        chk("rst rf_we", 32'(bus.rf_we), 0);
        @(negedge clk) reset = 1;
        tick();
        // store base 0x10, grant always
        sw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        bus.op_valid = 1; bus.op_store = 1; bus.op_base = 8'h10; bus.mem_gnt = 1;
        bus.store_vec = 128'h44444444_33333333_22222222_11111111;
        #1;
        chk("st t0 op_ready", 32'(bus.op_ready), 1);
        chk("st t0 pc_stall", 32'(bus.pc_stall), 1);
        tick();
        bus.op_valid = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("st req %0d", k), 32'(bus.mem_req), 1);
            chk($sformatf("st we %0d", k), 32'(bus.mem_we), 1);
            chk($sformatf("st addr %0d", k), 32'(bus.mem_addr), 32'h10 + k);
            chk($sformatf("st wdata %0d", k), bus.mem_wdata, sw[k]);
            chk($sformatf("st lane %0d", k), 32'(bus.lane), k);
            chk($sformatf("st stall %0d", k), 32'(bus.pc_stall), 1);
            chk($sformatf("st rf_we %0d", k), 32'(bus.rf_we), 0);
            tick();
        end
        chk("st t5 done", 32'(bus.done), 1);
        chk("st t5 pc_stall", 32'(bus.pc_stall), 0);
        chk("st t5 op_ready", 32'(bus.op_ready), 0);
        tick();
        chk("st idle done", 32'(bus.done), 0);
        chk("st idle op_ready", 32'(bus.op_ready), 1);
        chk("st mem 0x10", mem[8'h10], 32'h11111111);
        chk("st mem 0x13", mem[8'h13], 32'h44444444);
        // load base 0x20 into r5
        for (int k = 0; k < 4; k++) mem[8'h20 + k] = 32'hA0 + k;
        bus.op_valid = 1; bus.op_store = 0; bus.op_base = 8'h20; bus.op_reg = 5;
        tick();
        bus.op_valid = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ld req %0d", k), 32'(bus.mem_req), 1);
            chk($sformatf("ld we %0d", k), 32'(bus.mem_we), 0);
            chk($sformatf("ld addr %0d", k), 32'(bus.mem_addr), 32'h20 + k);
            chk($sformatf("ld issue rf_we %0d", k), 32'(bus.rf_we), 0);
            tick();
            chk($sformatf("ld rf_we %0d", k), 32'(bus.rf_we), 1);
            chk($sformatf("ld rd req %0d", k), 32'(bus.mem_req), 0);
            chk($sformatf("ld waddr_r %0d", k), 32'(bus.rf_waddr_r), 5);
            chk($sformatf("ld waddr_c %0d", k), 32'(bus.rf_waddr_c), k);
            chk($sformatf("ld wdata %0d", k), bus.rf_wdata, 32'hA0 + k);
            tick();
        end
        chk("ld t9 done", 32'(bus.done), 1);
        chk("ld t9 rf_we", 32'(bus.rf_we), 0);
        tick();
        // store with grant withheld for 3 cycles on lane 1
        bus.op_valid = 1; bus.op_store = 1; bus.op_base = 8'h30; bus.mem_gnt = 1;
        bus.store_vec = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
        tick();
        bus.op_valid = 0;
        chk("gs t1 addr", 32'(bus.mem_addr), 32'h30);
        tick();
        bus.mem_gnt = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("gs hold addr %0d", c), 32'(bus.mem_addr), 32'h31);
            chk($sformatf("gs hold wdata %0d", c), bus.mem_wdata, 32'hCAFE0001);
            chk($sformatf("gs hold we %0d", c), 32'(bus.mem_we), 1);
            tick();
        end
        bus.mem_gnt = 1;
        #1;
        chk("gs t5 addr", 32'(bus.mem_addr), 32'h31);
        tick();
        chk("gs t6 addr", 32'(bus.mem_addr), 32'h32);
        tick();
        chk("gs t7 wdata", bus.mem_wdata, 32'hCAFE0003);
        tick();
        chk("gs t8 done", 32'(bus.done), 1);
        tick();
        chk("gs mem 0x31", mem[8'h31], 32'hCAFE0001);
        // load wrapping past 0xFF
        mem[8'hFE] = 32'hB0; mem[8'hFF] = 32'hB1; mem[8'h00] = 32'hB2; mem[8'h01] = 32'hB3;
        bus.op_valid = 1; bus.op_store = 0; bus.op_base = 8'hFE; bus.op_reg = 9;
        tick();
        bus.op_valid = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wr addr %0d", k), 32'(bus.mem_addr), (32'hFE + k) & 32'hFF);
            tick();
            chk($sformatf("wr wdata %0d", k), bus.rf_wdata, 32'hB0 + k);
            tick();
        end
        chk("wr done", 32'(bus.done), 1);
        tick();
        // reset during lane-2 RDWAIT of a load
        bus.op_valid = 1; bus.op_store = 0; bus.op_base = 8'h20; bus.op_reg = 2;
        tick();
        bus.op_valid = 0;
        for (int c = 0; c < 5; c++) tick();
        chk("ab rf_we pre", 32'(bus.rf_we), 1);
        chk("ab lane pre", 32'(bus.lane), 2);
        reset = 0;
        #1;
        chk("ab rf_we", 32'(bus.rf_we), 0);
        chk("ab op_ready", 32'(bus.op_ready), 1);
        chk("ab done", 32'(bus.done), 0);
        chk("ab lane", 32'(bus.lane), 0);
        @(negedge clk) reset = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            seen = seen | bus.rf_we | bus.done | bus.mem_req;
        end
        chk("ab quiet", 32'(seen), 0);
        chk("ab op_ready post", 32'(bus.op_ready), 1);
        // back-to-back store then load, store_vec changed mid-store
        bus.op_valid = 1; bus.op_store = 1; bus.op_base = 8'h40; bus.mem_gnt = 1;
        bus.store_vec = 128'h00000D04_00000D03_00000D02_00000D01;
        tick();
        bus.op_store = 0; bus.op_base = 8'h20; bus.op_reg = 7; bus.store_vec = '1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bb wdata %0d", k), bus.mem_wdata, 32'hD01 + k);
            tick();
        end
        chk("bb done", 32'(bus.done), 1);
        chk("bb done op_ready", 32'(bus.op_ready), 0);
        chk("bb done pc_stall", 32'(bus.pc_stall), 0);
        tick();
        chk("bb accept op_ready", 32'(bus.op_ready), 1);
        chk("bb accept pc_stall", 32'(bus.pc_stall), 1);
        tick();
        bus.op_valid = 0;
        chk("bb ld we", 32'(bus.mem_we), 0);
        chk("bb ld addr", 32'(bus.mem_addr), 32'h20);
        chk("bb mem 0x42", mem[8'h42], 32'hD03);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = bus.done;
        end
        chk("bb ld done", 32'(seen), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
